// File: rtl/ddr3_fb_addr_gen_pkg.sv
// Shared constants and helpers for the DDR3 multi-buffer frame-store address generator.
package ddr3_fb_addr_gen_pkg;

  localparam int unsigned MEM_ADDR_SIZE = 28;
  localparam int unsigned CACHE_WIDTH   = 128;
  localparam int unsigned BURST_LENGTH  = 8;
  localparam int unsigned BUF_IDX_W     = 2;

  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  // Next buffer index, wrapping at num_buf.
  function automatic buf_idx_t buf_inc(input buf_idx_t idx, input int unsigned num_buf);
    if (32'(idx) + 32'd1 >= num_buf) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/ddr3_fb_addr_gen_fb_buf_rotator.sv
// Frame-buffer rotator: vsync edge detect, write/done/read buffer selection and
// the rule that keeps the writer off the buffer currently being read.
module ddr3_fb_addr_gen_fb_buf_rotator
  import ddr3_fb_addr_gen_pkg::*;
#(
  parameter int unsigned NUM_BUF = 3
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     vsync_i,
  input  logic     wr_active_i,    // current write frame holds at least one burst
  input  logic     rd_frame_start_i,
  output logic     vs_rise_o,
  output buf_idx_t wr_buf_o,
  output buf_idx_t wr_buf_nxt_o,   // buffer that a same-cycle burst must target
  output buf_idx_t rd_buf_o,
  output buf_idx_t rd_buf_nxt_o,   // buffer that a same-cycle read must target
  output logic     frame_valid_o
);

  logic     vsync_q;
  buf_idx_t wr_buf_q, wr_buf_d;
  buf_idx_t done_buf_q, done_buf_d;
  buf_idx_t rd_buf_q, rd_buf_d;
  logic     frame_valid_q, frame_valid_d;
  logic     vs_rise;
  buf_idx_t wr_step;

  assign vs_rise = vsync_i & ~vsync_q;

  // Next-state for buffer rotation and read-frame latch.
  always_comb begin
    wr_buf_d      = wr_buf_q;
    done_buf_d    = done_buf_q;
    frame_valid_d = frame_valid_q;
    rd_buf_d      = rd_buf_q;
    wr_step       = buf_inc(wr_buf_q, NUM_BUF);

    // Empty frames leave the rotation untouched.
    if (vs_rise && wr_active_i) begin
      done_buf_d    = wr_buf_q;
      frame_valid_d = 1'b1;
      if (wr_step == rd_buf_q && NUM_BUF >= 3) begin
        wr_step = buf_inc(wr_step, NUM_BUF);
      end
      wr_buf_d = wr_step;
    end

    // Forward a same-cycle completion so the reader never sees a stale frame.
    if (rd_frame_start_i && frame_valid_d) begin
      rd_buf_d = done_buf_d;
    end
  end

  // Rotation state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q       <= 1'b0;
      wr_buf_q      <= '0;
      done_buf_q    <= '0;
      rd_buf_q      <= buf_idx_t'(NUM_BUF - 1);
      frame_valid_q <= 1'b0;
    end else begin
      vsync_q       <= vsync_i;
      wr_buf_q      <= wr_buf_d;
      done_buf_q    <= done_buf_d;
      rd_buf_q      <= rd_buf_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign vs_rise_o     = vs_rise;
  assign wr_buf_o      = wr_buf_q;
  assign wr_buf_nxt_o  = wr_buf_d;
  assign rd_buf_o      = rd_buf_q;
  assign rd_buf_nxt_o  = rd_buf_d;
  assign frame_valid_o = frame_valid_q;

endmodule

// File: rtl/ddr3_fb_addr_gen.sv
// Multi-buffer DDR3 frame-store address generator.
// Write side fills one of NUM_BUF buffers and rotates on vsync; read side replays the
// latest complete frame. Optional DDR3_FB_OVF_EN adds wr_ovf / rd_wrap status outputs.
module ddr3_fb_addr_gen
  import ddr3_fb_addr_gen_pkg::*;
#(
  parameter int unsigned          ADDR_W       = MEM_ADDR_SIZE,
  parameter int unsigned          DATA_W       = CACHE_WIDTH,
  parameter int unsigned          BURST_LEN    = BURST_LENGTH,
  parameter int unsigned          NUM_BUF      = 3,
  parameter logic [ADDR_W-1:0]    BASE_ADDR    = 28'h000_0100,
  parameter logic [ADDR_W-1:0]    FRAME_STRIDE = 28'h080_0000,
  parameter int unsigned          FRAME_BURSTS = 8100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              ddr3_din_en,
  input  logic [DATA_W-1:0] ddr3_din,
  output logic              ddr3_wr_en,
  output logic [ADDR_W-1:0] ddr3_wr_addr,
  output logic [DATA_W-1:0] ddr3_wr_data,
  input  logic              rd_frame_start,
  input  logic              ddr3_dout_req_i,
  output logic              ddr3_dout_req_o,
  output logic [ADDR_W-1:0] ddr3_rd_addr,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
`ifdef DDR3_FB_OVF_EN
  output logic              wr_ovf,
  output logic              rd_wrap,
`endif
  output logic              frame_valid
);

  localparam int unsigned CntW = $clog2(FRAME_BURSTS + 1);

  logic              vs_rise;
  buf_idx_t          wr_buf, wr_buf_nxt, rd_buf, rd_buf_nxt;

  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d, wr_cnt_base;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d, rd_cnt_base;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_accept;
`ifdef DDR3_FB_OVF_EN
  logic              wr_ovf_q, wr_ovf_d;
  logic              rd_wrap_q, rd_wrap_d;
`endif

  function automatic logic [ADDR_W-1:0] calc_addr(input buf_idx_t idx, input logic [CntW-1:0] cnt);
    return BASE_ADDR + ADDR_W'(idx) * FRAME_STRIDE + ADDR_W'(cnt) * ADDR_W'(BURST_LEN);
  endfunction

  ddr3_fb_addr_gen_fb_buf_rotator #(
    .NUM_BUF(NUM_BUF)
  ) u_fb_buf_rotator (
    .clk_i           (clk),
    .rst_i           (rst),
    .vsync_i         (vsync),
    .wr_active_i     (wr_cnt_q != '0),
    .rd_frame_start_i(rd_frame_start),
    .vs_rise_o       (vs_rise),
    .wr_buf_o        (wr_buf),
    .wr_buf_nxt_o    (wr_buf_nxt),
    .rd_buf_o        (rd_buf),
    .rd_buf_nxt_o    (rd_buf_nxt),
    .frame_valid_o   (frame_valid)
  );

  // Write path: a frame switch restarts at offset 0 of the new buffer in the same cycle.
  always_comb begin
    wr_cnt_base = vs_rise ? '0 : wr_cnt_q;
    wr_accept   = ddr3_din_en && (wr_cnt_base < CntW'(FRAME_BURSTS));
    wr_en_d     = wr_accept;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_cnt_d    = wr_cnt_base;
    if (wr_accept) begin
      wr_addr_d = calc_addr(wr_buf_nxt, wr_cnt_base);
      wr_data_d = ddr3_din;
      wr_cnt_d  = wr_cnt_base + CntW'(1);
    end
  end

  // Read path: frame start resets the offset; the counter loops so a frame repeats.
  always_comb begin
    rd_cnt_base = rd_frame_start ? '0 : rd_cnt_q;
    req_d       = ddr3_dout_req_i;
    rd_addr_d   = rd_addr_q;
    rd_cnt_d    = rd_cnt_base;
    if (ddr3_dout_req_i) begin
      rd_addr_d = calc_addr(rd_buf_nxt, rd_cnt_base);
      rd_cnt_d  = (rd_cnt_base == CntW'(FRAME_BURSTS - 1)) ? '0 : rd_cnt_base + CntW'(1);
    end
  end

`ifdef DDR3_FB_OVF_EN
  // Sticky drop flag and read roll-over pulse.
  always_comb begin
    wr_ovf_d  = wr_ovf_q;
    if (vs_rise) begin
      wr_ovf_d = 1'b0;
    end else if (ddr3_din_en && !wr_accept) begin
      wr_ovf_d = 1'b1;
    end
    rd_wrap_d = ddr3_dout_req_i && !rd_frame_start &&
                (rd_cnt_base == CntW'(FRAME_BURSTS - 1));
  end

  // Status flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ovf_q  <= 1'b0;
      rd_wrap_q <= 1'b0;
    end else begin
      wr_ovf_q  <= wr_ovf_d;
      rd_wrap_q <= rd_wrap_d;
    end
  end

  assign wr_ovf  = wr_ovf_q;
  assign rd_wrap = rd_wrap_q;
`endif

  // Counter and output pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      req_q     <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      req_q     <= req_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign ddr3_wr_en      = wr_en_q;
  assign ddr3_wr_addr    = wr_addr_q;
  assign ddr3_wr_data    = wr_data_q;
  assign ddr3_dout_req_o = req_q;
  assign ddr3_rd_addr    = rd_addr_q;
  assign wr_buf_idx      = wr_buf;
  assign rd_buf_idx      = rd_buf;

endmodule

// File: tb/tb_ddr3_fb_addr_gen.sv
// Self-checking bench for ddr3_fb_addr_gen: directed plan steps, then random traffic
// checked against a frame-level behavioural model.
module tb_ddr3_fb_addr_gen;

  localparam int unsigned AW     = 28;
  localparam int unsigned DW     = 128;
  localparam int          NB     = 3;
  localparam int          BL     = 8;
  localparam int          BASE   = 'h100;
  localparam int          STRIDE = 'h1000;
  localparam int          FB     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          din_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rfs = 1'b0;
  logic          req_i = 1'b0;
  logic          req_o;
  logic [AW-1:0] rd_addr;
  logic [1:0]    wr_buf_idx;
  logic [1:0]    rd_buf_idx;
  logic          frame_valid;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (frame-level view).
  int            m_wr_buf, m_done, m_rd_buf, m_wr_cnt, m_rd_cnt;
  bit            m_valid, m_vs_prev;
  bit            e_wr_en, e_req;
  logic [AW-1:0] e_wr_addr, e_rd_addr;
  logic [DW-1:0] e_wr_data;

  always #5 clk = ~clk;

  ddr3_fb_addr_gen #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BURST_LEN   (BL),
    .NUM_BUF     (NB),
    .BASE_ADDR   (28'h000_0100),
    .FRAME_STRIDE(28'h000_1000),
    .FRAME_BURSTS(FB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .vsync          (vsync),
    .ddr3_din_en    (din_en),
    .ddr3_din       (din),
    .ddr3_wr_en     (wr_en),
    .ddr3_wr_addr   (wr_addr),
    .ddr3_wr_data   (wr_data),
    .rd_frame_start (rfs),
    .ddr3_dout_req_i(req_i),
    .ddr3_dout_req_o(req_o),
    .ddr3_rd_addr   (rd_addr),
    .wr_buf_idx     (wr_buf_idx),
    .rd_buf_idx     (rd_buf_idx),
    .frame_valid    (frame_valid)
  );

  function automatic logic [AW-1:0] m_addr(input int idx, input int cnt);
    return AW'(BASE + idx * STRIDE + cnt * BL);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare all outputs.
  task automatic step(input bit r, input bit vs, input bit en, input bit fs, input bit rq);
    bit            vr, done_upd;
    int            nw, nd, nr, wc, rc;
    bit            nv;
    logic [DW-1:0] d;
    d      = {$urandom, $urandom, $urandom, $urandom};
    rst    = r;
    vsync  = vs;
    din_en = en;
    din    = d;
    rfs    = fs;
    req_i  = rq;
    if (r) begin
      m_wr_buf = 0; m_done = 0; m_rd_buf = NB - 1; m_wr_cnt = 0; m_rd_cnt = 0;
      m_valid = 0; m_vs_prev = 0;
      e_wr_en = 0; e_req = 0; e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0;
    end else begin
      vr = vs && !m_vs_prev;
      done_upd = vr && (m_wr_cnt != 0);
      nw = m_wr_buf; nd = m_done; nv = m_valid; wc = m_wr_cnt;
      if (done_upd) begin
        nd = m_wr_buf;
        nv = 1;
        nw = (m_wr_buf + 1) % NB;
        if (nw == m_rd_buf && NB >= 3) nw = (nw + 1) % NB;
      end
      if (vr) wc = 0;
      e_wr_en = en && (wc < FB);
      if (e_wr_en) begin
        e_wr_addr = m_addr(nw, wc);
        e_wr_data = d;
        wc++;
      end
      nr = m_rd_buf; rc = m_rd_cnt;
      if (fs) begin
        if (nv) nr = nd;
        rc = 0;
      end
      e_req = rq;
      if (rq) begin
        e_rd_addr = m_addr(nr, rc);
        rc = (rc + 1) % FB;
      end
      m_wr_buf = nw; m_done = nd; m_valid = nv; m_wr_cnt = wc;
      m_rd_buf = nr; m_rd_cnt = rc; m_vs_prev = vs;
    end
    @(posedge clk);
    #1;
    chk("wr_en", DW'(wr_en), DW'(e_wr_en));
    chk("wr_addr", DW'(wr_addr), DW'(e_wr_addr));
    if (e_wr_en) chk("wr_data", wr_data, e_wr_data);
    chk("req_o", DW'(req_o), DW'(e_req));
    chk("rd_addr", DW'(rd_addr), DW'(e_rd_addr));
    chk("wr_buf_idx", DW'(wr_buf_idx), DW'(m_wr_buf));
    chk("rd_buf_idx", DW'(rd_buf_idx), DW'(m_rd_buf));
    chk("frame_valid", DW'(frame_valid), DW'(m_valid));
  endtask

  initial begin
    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_rd_buf", DW'(rd_buf_idx), DW'(2));
    chk("rst_wr_en", DW'(wr_en), DW'(0));

    // Three bursts into buffer 0.
    step(0, 0, 1, 0, 0);
    chk("plan_w0", DW'(wr_addr), DW'(28'h100));
    step(0, 0, 1, 0, 0);
    chk("plan_w1", DW'(wr_addr), DW'(28'h108));
    step(0, 0, 1, 0, 0);
    chk("plan_w2", DW'(wr_addr), DW'(28'h110));
    chk("plan_wbuf0", DW'(wr_buf_idx), DW'(0));
    step(0, 0, 0, 0, 0);
    chk("plan_idle_hold", DW'(wr_addr), DW'(28'h110));
    step(0, 0, 1, 0, 0);
    chk("plan_w3", DW'(wr_addr), DW'(28'h118));

    // Fifth burst dropped.
    step(0, 0, 1, 0, 0);
    chk("plan_drop_en", DW'(wr_en), DW'(0));
    chk("plan_drop_addr", DW'(wr_addr), DW'(28'h118));

    // Frame switch, then an empty frame.
    step(0, 1, 0, 0, 0);
    chk("plan_vs_valid", DW'(frame_valid), DW'(1));
    chk("plan_vs_wbuf", DW'(wr_buf_idx), DW'(1));
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("plan_empty_wbuf", DW'(wr_buf_idx), DW'(1));
    step(0, 0, 1, 0, 0);
    chk("plan_buf1_addr", DW'(wr_addr), DW'(28'h1100));

    // Read frame 0 with wrap.
    step(0, 0, 0, 1, 0);
    chk("plan_rd_buf0", DW'(rd_buf_idx), DW'(0));
    step(0, 0, 0, 0, 1);
    chk("plan_r0", DW'(rd_addr), DW'(28'h100));
    step(0, 0, 0, 0, 1);
    chk("plan_r1", DW'(rd_addr), DW'(28'h108));
    step(0, 0, 0, 0, 1);
    chk("plan_r2", DW'(rd_addr), DW'(28'h110));
    step(0, 0, 0, 0, 1);
    chk("plan_r3", DW'(rd_addr), DW'(28'h118));
    step(0, 0, 0, 0, 1);
    chk("plan_r_wrap", DW'(rd_addr), DW'(28'h100));
    step(0, 0, 0, 0, 0);
    chk("plan_req_low", DW'(req_o), DW'(0));

    // Build rd_buf=1, wr_buf=0, then exercise the skip rule.
    step(0, 1, 0, 0, 0);             // frame 1 done, wr -> 2
    step(0, 0, 0, 1, 0);             // reader takes buffer 1
    chk("plan_rd_buf1", DW'(rd_buf_idx), DW'(1));
    step(0, 0, 1, 0, 0);
    chk("plan_buf2_addr", DW'(wr_addr), DW'(28'h2100));
    step(0, 1, 0, 0, 0);             // wr -> 0
    chk("plan_wbuf_wrap", DW'(wr_buf_idx), DW'(0));
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);             // wr would hit reader's buffer 1, skips to 2
    chk("plan_skip_wbuf", DW'(wr_buf_idx), DW'(2));
    chk("plan_skip_addr", DW'(wr_addr), DW'(28'h2100));
    step(0, 0, 0, 0, 0);

    // Random traffic against the model, with a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      bit vs_n;
      vs_n = ($urandom_range(0, 5) == 0) ? ~vsync : vsync;
      if (i == 300) begin
        step(1, vs_n, 1, 1, 1);
        chk("midrst_wr_en", DW'(wr_en), DW'(0));
        chk("midrst_req", DW'(req_o), DW'(0));
      end else begin
        step(0, vs_n, 1'($urandom_range(0, 1)), $urandom_range(0, 12) == 0,
             1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
